// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - registered 3-to-8 one-hot decoder with enable
// Optional out_valid output when DECODER_3TO8_VALID_EN is defined.
module decoder_3to8 #(
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] in,
   input  logic       en,
`ifdef DECODER_3TO8_VALID_EN
   output logic       out_valid,
`endif
   output logic [7:0] out
);

   // XOR mask applies the output polarity to both the reset value and the decode
   localparam logic [7:0] POL_MASK = {8{OUT_ACTIVE_LOW}};

   logic [7:0] raw;

   always_comb begin
      raw = 8'h00;
      if (en) begin
         raw[in] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= POL_MASK;
      end else begin
         out <= raw ^ POL_MASK;
      end
   end

`ifdef DECODER_3TO8_VALID_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= en;
      end
   end
`endif

endmodule

// File: tb/tb_decoder_3to8.sv
// tb/tb_decoder_3to8.sv - self-checking bench for decoder_3to8, both polarities
// Covers out_valid when DECODER_3TO8_VALID_EN is defined.
module tb_decoder_3to8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] in = 3'd0;
   logic       en = 1'b0;
   logic [7:0] out;
   logic [7:0] out_lo;
`ifdef DECODER_3TO8_VALID_EN
   logic       out_valid;
   logic       out_valid_lo;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) dut_hi (
      .clk(clk),
      .rst_n(rst_n),
      .in(in),
      .en(en),
`ifdef DECODER_3TO8_VALID_EN
      .out_valid(out_valid),
`endif
      .out(out)
   );

   decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) dut_lo (
      .clk(clk),
      .rst_n(rst_n),
      .in(in),
      .en(en),
`ifdef DECODER_3TO8_VALID_EN
      .out_valid(out_valid_lo),
`endif
      .out(out_lo)
   );

   // Reference: a power of two for the code when enabled, optionally complemented
   function automatic logic [7:0] model(input logic e, input logic [2:0] c, input bit low);
      int v;
      v = e ? (1 << c) : 0;
      if (low) v = ~v;
      return v[7:0];
   endfunction

   task automatic test_reset();
      en = 1'b0;
      in = 3'd0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_hi: got %h expected 00", out); end
      checks++; if (out_lo !== 8'hFF) begin errors++; $display("FAIL reset_lo: got %h expected FF", out_lo); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      en = 1'b1;
      in = 3'd3;
      @(posedge clk); #1;
      checks++; if (out !== 8'h08) begin errors++; $display("FAIL post_reset_decode: got %h expected 08", out); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL async_reset_hi: got %h expected 00", out); end
      checks++; if (out_lo !== 8'hFF) begin errors++; $display("FAIL async_reset_lo: got %h expected FF", out_lo); end
`ifdef DECODER_3TO8_VALID_EN
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL held_in_reset: got %h expected 00", out); end
      @(posedge clk); #1;
      checks++; if (out !== 8'h08) begin errors++; $display("FAIL first_after_release: got %h expected 08", out); end
   endtask

   task automatic test_sweep();
      logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      for (int i = 0; i < 8; i++) begin
         en = 1'b1;
         in = 3'(i);
         @(posedge clk); #1;
         checks++; if (out !== tbl[i]) begin errors++; $display("FAIL sweep_hi[%0d]: got %h expected %h", i, out, tbl[i]); end
         checks++; if (out_lo !== ~tbl[i]) begin errors++; $display("FAIL sweep_lo[%0d]: got %h expected %h", i, out_lo, ~tbl[i]); end
      end
   endtask

   task automatic test_disable();
      en = 1'b0;
      in = 3'd5;
      @(posedge clk); #1;
      checks++; if (out !== 8'h00) begin errors++; $display("FAIL disable_hi: got %h expected 00", out); end
      checks++; if (out_lo !== 8'hFF) begin errors++; $display("FAIL disable_lo: got %h expected FF", out_lo); end
      en = 1'b1;
      @(posedge clk); #1;
      checks++; if (out !== 8'h20) begin errors++; $display("FAIL reenable_hi: got %h expected 20", out); end
   endtask

   task automatic test_latency();
      en = 1'b1;
      in = 3'd2;
      @(posedge clk); #1;
      checks++; if (out !== 8'h04) begin errors++; $display("FAIL latency_first: got %h expected 04", out); end
      in = 3'd6;
      #2;
      checks++; if (out !== 8'h04) begin errors++; $display("FAIL latency_between_edges: got %h expected 04", out); end
      @(posedge clk); #1;
      checks++; if (out !== 8'h40) begin errors++; $display("FAIL latency_after_edge: got %h expected 40", out); end
   endtask

   task automatic test_active_low();
      en = 1'b1;
      in = 3'd1;
      @(posedge clk); #1;
      checks++; if (out_lo !== 8'hFD) begin errors++; $display("FAIL active_low_sel1: got %h expected FD", out_lo); end
      en = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_lo !== 8'hFF) begin errors++; $display("FAIL active_low_idle: got %h expected FF", out_lo); end
   endtask

   task automatic test_back_to_back();
      logic       pat [3] = '{1'b1, 1'b0, 1'b1};
      logic [2:0] code;
      for (int i = 0; i < 3; i++) begin
         en = pat[i];
         code = 3'($urandom_range(0, 7));
         in = code;
         @(posedge clk); #1;
         checks++; if (out !== model(pat[i], code, 1'b0)) begin errors++; $display("FAIL toggle_hi[%0d]: got %h expected %h", i, out, model(pat[i], code, 1'b0)); end
`ifdef DECODER_3TO8_VALID_EN
         checks++; if (out_valid !== pat[i]) begin errors++; $display("FAIL toggle_valid[%0d]: got %b expected %b", i, out_valid, pat[i]); end
         checks++; if (out_valid_lo !== pat[i]) begin errors++; $display("FAIL toggle_valid_lo[%0d]: got %b expected %b", i, out_valid_lo, pat[i]); end
`endif
      end
   endtask

   task automatic test_random();
      logic       e;
      logic [2:0] c;
      for (int i = 0; i < 300; i++) begin
         e = 1'($urandom_range(0, 1));
         c = 3'($urandom_range(0, 7));
         en = e;
         in = c;
         @(posedge clk); #1;
         checks++; if (out !== model(e, c, 1'b0)) begin errors++; $display("FAIL random_hi[%0d]: got %h expected %h", i, out, model(e, c, 1'b0)); end
         checks++; if (out_lo !== model(e, c, 1'b1)) begin errors++; $display("FAIL random_lo[%0d]: got %h expected %h", i, out_lo, model(e, c, 1'b1)); end
         checks++; if ($countones(out) > 1) begin errors++; $display("FAIL random_onehot[%0d]: got %h expected at most one bit set", i, out); end
`ifdef DECODER_3TO8_VALID_EN
         checks++; if (out_valid !== e) begin errors++; $display("FAIL random_valid[%0d]: got %b expected %b", i, out_valid, e); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_disable();
      test_latency();
      test_active_low();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
